// File: rtl/lsu_dmem_master_if.sv
// Core-side request/response and data-memory bus of the load/store unit.
// The master modport is the LSU's view; the slave modport is the core-plus-memory side.
interface lsu_dmem_master_if #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  MemRead;
  logic                  MemWrite;
  logic [2:0]            Funct3;
  logic [DM_ADDRESS-1:0] addr;
  logic [DATA_W-1:0]     wd;
  logic                  resp_valid;
  logic [DATA_W-1:0]     rd;
  logic [DM_ADDRESS-1:0] mem_addr;
  logic                  mem_re;
  logic [3:0]            mem_wr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W-1:0]     mem_rdata;

  modport master (
    input  req_valid, MemRead, MemWrite, Funct3, addr, wd, mem_rdata,
    output req_ready, resp_valid, rd, mem_addr, mem_re, mem_wr, mem_wdata
  );

  modport slave (
    output req_valid, MemRead, MemWrite, Funct3, addr, wd, mem_rdata,
    input  req_ready, resp_valid, rd, mem_addr, mem_re, mem_wr, mem_wdata
  );
endinterface

// File: rtl/lsu_dmem_master.sv
// Load/store unit: turns byte/half/word requests into word-aligned memory
// accesses, splitting a word-crossing access into two consecutive words.
module lsu_dmem_master #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input logic               clk,
  input logic               reset,
  lsu_dmem_master_if.master bus
);

  typedef enum logic [2:0] {IDLE, A1, A2, CAP, RESP} state_t;

  state_t                state, state_nx;
  logic                  ready;
  logic                  accept;
  logic [2:0]            n_in;
  logic                  split_in;

  logic                  is_load_q;
  logic                  zext_q;
  logic                  split_q;
  logic [1:0]            size_q;
  logic [1:0]            off_q;
  logic [DM_ADDRESS-1:0] w0_q;
  logic [DATA_W-1:0]     wd_q;
  logic [DATA_W-1:0]     lo_q;
  logic [DATA_W-1:0]     rd_q;

  logic [3:0]            base_mask;
  logic [7:0]            lane_mask;
  logic [2*DATA_W-1:0]   wide_wd;
  logic [2*DATA_W-1:0]   both_words;
  logic [DATA_W-1:0]     raw_val;
  logic [DATA_W-1:0]     load_val;

  assign ready  = (state == IDLE) && !reset;
  assign accept = bus.req_valid && ready && (bus.MemRead || bus.MemWrite);

  always_comb begin
    case (bus.Funct3[1:0])
      2'b00:   n_in = 3'd1;
      2'b01:   n_in = 3'd2;
      default: n_in = 3'd4;
    endcase
    split_in = (3'(bus.addr[1:0]) + n_in) > 3'd4;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      rd_q  <= '0;
    end else begin
      state <= state_nx;
      if (state == CAP) rd_q <= load_val;
    end
  end

  // NOTE: request and datapath registers carry no reset; they are always
  // written at accept before being consumed, so reset would only cost muxes.
  always_ff @(posedge clk) begin
    if (accept) begin
      is_load_q <= bus.MemRead;
      zext_q    <= bus.Funct3[2];
      size_q    <= bus.Funct3[1:0];
      off_q     <= bus.addr[1:0];
      split_q   <= split_in;
      w0_q      <= {bus.addr[DM_ADDRESS-1:2], 2'b00};
      wd_q      <= bus.wd;
    end
    if (state == A2 && is_load_q) lo_q <= bus.mem_rdata;
  end

  // Lanes [3:0] belong to W0 and [7:4] to W1 once shifted by the byte offset.
  always_comb begin
    case (size_q)
      2'b00:   base_mask = 4'b0001;
      2'b01:   base_mask = 4'b0011;
      default: base_mask = 4'b1111;
    endcase
    lane_mask = {4'b0000, base_mask} << off_q;
    wide_wd   = {{DATA_W{1'b0}}, wd_q} << {off_q, 3'b000};
  end

  // In CAP mem_rdata holds the last word read; for a split it is W1 and lo_q holds W0.
  always_comb begin
    both_words = split_q ? {bus.mem_rdata, lo_q} : {{DATA_W{1'b0}}, bus.mem_rdata};
    raw_val    = DATA_W'(both_words >> {off_q, 3'b000});
    case (size_q)
      2'b00:   load_val = zext_q ? {{(DATA_W-8){1'b0}}, raw_val[7:0]}
                                 : {{(DATA_W-8){raw_val[7]}}, raw_val[7:0]};
      2'b01:   load_val = zext_q ? {{(DATA_W-16){1'b0}}, raw_val[15:0]}
                                 : {{(DATA_W-16){raw_val[15]}}, raw_val[15:0]};
      default: load_val = raw_val;
    endcase
  end

  // NOTE: every output and next-state value gets a default first, so no path
  // through the case can leave one unassigned and infer a latch.
  always_comb begin
    state_nx      = state;
    bus.resp_valid = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_re     = 1'b0;
    bus.mem_wr     = 4'b0000;
    bus.mem_wdata  = '0;
    case (state)
      IDLE: if (accept) state_nx = A1;
      A1: begin
        bus.mem_addr = w0_q;
        if (is_load_q) begin
          bus.mem_re = 1'b1;
        end else begin
          bus.mem_wr    = lane_mask[3:0];
          bus.mem_wdata = wide_wd[DATA_W-1:0];
        end
        if (split_q)        state_nx = A2;
        else if (is_load_q) state_nx = CAP;
        else                state_nx = RESP;
      end
      A2: begin
        bus.mem_addr = w0_q + DM_ADDRESS'(4);
        if (is_load_q) begin
          bus.mem_re = 1'b1;
        end else begin
          bus.mem_wr    = lane_mask[7:4];
          bus.mem_wdata = wide_wd[2*DATA_W-1:DATA_W];
        end
        state_nx = is_load_q ? CAP : RESP;
      end
      CAP:  state_nx = RESP;
      RESP: begin
        bus.resp_valid = 1'b1;
        state_nx       = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    // Reset silences the bus in the same cycle so an aborted split never writes W1.
    if (reset) begin
      bus.resp_valid = 1'b0;
      bus.mem_addr   = '0;
      bus.mem_re     = 1'b0;
      bus.mem_wr     = 4'b0000;
      bus.mem_wdata  = '0;
    end
  end

  assign bus.req_ready = ready;
  assign bus.rd        = rd_q;

endmodule

// File: tb/tb_lsu_dmem_master.sv
// Scoreboard bench for lsu_dmem_master: a byte-array reference model predicts
// every response; a monitor pops and compares when resp_valid pulses.
module tb_lsu_dmem_master;
  localparam int AW = 9;
  localparam int MSZ = 512;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lsu_dmem_master_if #(.DM_ADDRESS(AW), .DATA_W(32)) bus ();
  lsu_dmem_master #(.DM_ADDRESS(AW), .DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        is_load;
    logic [31:0] rd;
    int          t_acc;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  exp_t        m_e;
  logic [7:0]  mem[MSZ];
  logic [7:0]  ref_mem[MSZ];
  logic [31:0] model_rd;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_err = 0;

  always @(posedge clk) cyc++;

  function automatic logic [7:0] init_byte(input int i);
    return 8'((i * 37 + 11) ^ (i >> 3));
  endfunction

  // Data memory: synchronous read, byte-lane writes, garbage when not reading.
  initial begin
    for (int i = 0; i < MSZ; i++) mem[i] = init_byte(i);
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      if (bus.mem_re)
        bus.mem_rdata <= {mem[int'(bus.mem_addr) + 3], mem[int'(bus.mem_addr) + 2],
                          mem[int'(bus.mem_addr) + 1], mem[int'(bus.mem_addr)]};
      else
        bus.mem_rdata <= $urandom;
      for (int i = 0; i < 4; i++)
        if (bus.mem_wr[i]) mem[int'({bus.mem_addr[AW-1:2], 2'b00}) + i] <= bus.mem_wdata[8*i +: 8];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  function automatic int nbytes(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction

  // Reference: bytes at consecutive addresses modulo memory size, then extend.
  function automatic logic [31:0] model_load(input logic [AW-1:0] a, input logic [2:0] f3);
    int n = nbytes(f3);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[(int'(a) + i) % MSZ];
    if (!f3[2] && n == 1) v = {{24{v[7]}}, v[7:0]};
    if (!f3[2] && n == 2) v = {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  task automatic model_store(input logic [AW-1:0] a, input logic [2:0] f3, input logic [31:0] d);
    for (int i = 0; i < nbytes(f3); i++) ref_mem[(int'(a) + i) % MSZ] = d[8*i +: 8];
  endtask

  task automatic wait_ready();
    int waited = 0;
    while (!bus.req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
  endtask

  // Called on a negedge; returns on the next negedge (the A1 cycle).
  task automatic issue(input bit ld, input logic [2:0] f3, input logic [AW-1:0] a,
                       input logic [31:0] d, output int t);
    exp_t e;
    bit   split;
    t = -1;
    wait_ready();
    if (!bus.req_ready) begin
      fail("req_ready timeout");
      return;
    end
    bus.req_valid = 1'b1;
    bus.MemRead   = ld;
    bus.MemWrite  = ld ? 1'($urandom) : 1'b1;
    bus.Funct3    = f3;
    bus.addr      = a;
    bus.wd        = d;
    t = cyc;
    split = (int'(a[1:0]) + nbytes(f3)) > 4;
    e.is_load = ld;
    e.t_acc   = t;
    e.lat     = ld ? (split ? 4 : 3) : (split ? 3 : 2);
    if (ld) model_rd = model_load(a, f3);
    else    model_store(a, f3, d);
    e.rd = model_rd;
    sb.push_back(e);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.MemRead   = 1'($urandom);
    bus.MemWrite  = 1'($urandom);
    bus.Funct3    = 3'($urandom);
    bus.addr      = AW'($urandom);
    bus.wd        = $urandom;
  endtask

  task automatic noop_req();
    wait_ready();
    bus.req_valid = 1'b1;
    bus.MemRead   = 1'b0;
    bus.MemWrite  = 1'b0;
    @(negedge clk);
    check("noop stays idle", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b0;
  endtask

  // Monitor: pops one expectation per response pulse.
  always @(negedge clk) begin
    if (bus.resp_valid) begin
      if (sb.size() == 0) begin
        fail("unexpected resp_valid");
      end else begin
        m_e = sb.pop_front();
        check("resp latency", 32'(cyc - m_e.t_acc), 32'(m_e.lat));
        check(m_e.is_load ? "load rd" : "store rd hold", bus.rd, m_e.rd);
      end
    end
    if (bus.mem_re || bus.mem_wr != 4'b0000)
      check("mem_addr aligned", 32'(bus.mem_addr[1:0]), 32'd0);
  end

  initial begin
    int t;
    int waited;
    logic [7:0] saved;
    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.MemRead   = 1'b0;
    bus.MemWrite  = 1'b0;
    bus.Funct3    = '0;
    bus.addr      = '0;
    bus.wd        = '0;
    model_rd      = '0;
    for (int i = 0; i < MSZ; i++) ref_mem[i] = init_byte(i);

    repeat (3) @(negedge clk);
    check("reset req_ready", 32'(bus.req_ready), 32'd0);
    check("reset resp_valid", 32'(bus.resp_valid), 32'd0);
    check("reset rd", bus.rd, 32'd0);
    check("reset mem_wr", 32'(bus.mem_wr), 32'd0);
    check("reset mem_re", 32'(bus.mem_re), 32'd0);
    check("reset mem_addr", 32'(bus.mem_addr), 32'd0);
    check("reset mem_wdata", bus.mem_wdata, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("ready after reset", 32'(bus.req_ready), 32'd1);

    // Aligned word store and load.
    issue(0, 3'b010, 9'h010, 32'hDEADBEEF, t);
    check("sw mem_wr", 32'(bus.mem_wr), 32'b1111);
    check("sw mem_addr", 32'(bus.mem_addr), 32'h010);
    check("sw mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
    check("sw mem_re", 32'(bus.mem_re), 32'd0);
    issue(1, 3'b010, 9'h010, 32'h0, t);
    check("lw mem_re", 32'(bus.mem_re), 32'd1);
    check("lw mem_wr", 32'(bus.mem_wr), 32'd0);

    // Byte store, signed and unsigned byte loads.
    issue(0, 3'b000, 9'h013, 32'h00000080, t);
    check("sb mem_wr", 32'(bus.mem_wr), 32'b1000);
    check("sb lane3", 32'(bus.mem_wdata[31:24]), 32'h80);
    issue(1, 3'b000, 9'h013, 32'h0, t);
    issue(1, 3'b100, 9'h013, 32'h0, t);

    // Halfword store, signed and unsigned halfword loads.
    issue(0, 3'b001, 9'h022, 32'h0000F00D, t);
    check("sh mem_wr", 32'(bus.mem_wr), 32'b1100);
    issue(1, 3'b001, 9'h022, 32'h0, t);
    issue(1, 3'b101, 9'h022, 32'h0, t);

    // Word store crossing into the next word, then read back.
    issue(0, 3'b010, 9'h006, 32'h44332211, t);
    check("split sw W0 addr", 32'(bus.mem_addr), 32'h004);
    check("split sw W0 wr", 32'(bus.mem_wr), 32'b1100);
    check("split sw W0 data", 32'(bus.mem_wdata[31:16]), 32'h2211);
    @(negedge clk);
    check("split sw W1 addr", 32'(bus.mem_addr), 32'h008);
    check("split sw W1 wr", 32'(bus.mem_wr), 32'b0011);
    check("split sw W1 data", 32'(bus.mem_wdata[15:0]), 32'h4433);
    issue(1, 3'b010, 9'h006, 32'h0, t);

    // Halfword load wrapping past the top of memory.
    issue(1, 3'b001, 9'h1FF, 32'h0, t);
    check("wrap W0 addr", 32'(bus.mem_addr), 32'h1FC);
    check("wrap W0 re", 32'(bus.mem_re), 32'd1);
    @(negedge clk);
    check("wrap W1 addr", 32'(bus.mem_addr), 32'h000);
    check("wrap W1 re", 32'(bus.mem_re), 32'd1);

    noop_req();

    // Reset during the second half of a split store: only W0 lanes change.
    saved = ref_mem[9'h0A8];
    issue(0, 3'b010, 9'h0A5, 32'hCAFEF00D, t);
    @(negedge clk);
    reset = 1'b1;
    void'(sb.pop_back());
    ref_mem[9'h0A8] = saved;
    model_rd = '0;
    @(negedge clk);
    check("abort mem_wr", 32'(bus.mem_wr), 32'd0);
    check("abort req_ready in reset", 32'(bus.req_ready), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("abort req_ready", 32'(bus.req_ready), 32'd1);
    check("abort rd cleared", bus.rd, 32'd0);
    issue(1, 3'b010, 9'h0A4, 32'h0, t);
    issue(1, 3'b010, 9'h0A8, 32'h0, t);

    // Random mix, including split and wrapping accesses.
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 15) == 0) noop_req();
      issue(1'($urandom), 3'($urandom), AW'($urandom), $urandom, t);
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    waited = 0;
    while (sb.size() != 0 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (sb.size() != 0) fail("responses outstanding at end");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/lsu_dmem_master.md
Name: lsu_dmem_master

Overview:
- Load/store unit between the core datapath and the word-wide data memory. The data memory has a synchronous read, byte-lane write enables and word-aligned addressing.
- Takes one load or store request per handshake. Drives word-aligned memory accesses with byte enables, shifts store data onto lanes, and extracts plus sign/zero-extends load data.
- Splits any access that crosses a word boundary into two consecutive word accesses; the core sees a single response.

Parameters:
- DM_ADDRESS, 9, byte-address width of the data memory.
- DATA_W, 32, data word width (the design is fixed at 4 byte lanes; only 32 is supported).

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- reset  in  1  synchronous reset, active-high.
- req_valid  in  1  core presents a request.
- req_ready  out  1  unit idle and accepting a request.
- MemRead  in  1  request is a load.
- MemWrite  in  1  request is a store.
- Funct3  in  3  access size/sign (instruction bits 14:12).
- addr  in  DM_ADDRESS  byte address.
- wd  in  DATA_W  store data, right-justified.
- resp_valid  out  1  one-cycle pulse: load data valid on rd, or store complete.
- rd  out  DATA_W  extended load data, held until the next response.
- mem_addr  out  DM_ADDRESS  word-aligned address; bits [1:0] always 0.
- mem_re  out  1  read strobe.
- mem_wr  out  4  byte-lane write enables; bit i writes byte i, little-endian.
- mem_wdata  out  DATA_W  lane-aligned write data.
- mem_rdata  in  DATA_W  read data, valid the cycle after mem_re.

Behaviour:
- Reset (synchronous):
  - State goes to IDLE.
  - resp_valid=0, rd=0, mem_addr=0, mem_re=0, mem_wr=0, mem_wdata=0.
  - req_ready=0 during any reset cycle.
- req_ready = (state==IDLE) && !reset.
- Accept occurs when req_valid && req_ready && (MemRead || MemWrite). If both are high, the request is a load. If neither is high, nothing is accepted and the state stays IDLE.
- Inputs are sampled only at accept; they are don't-care afterwards.
- Size n from Funct3[1:0]:
  - 00 gives n=1.
  - 01 gives n=2.
  - 10 and 11 give n=4.
- Funct3[2]=1 means zero-extend; it is ignored for stores and when n=4.
- Offset o=addr[1:0]. The access splits iff o+n>4.
- First word W0 = addr with [1:0] cleared; lanes o..min(o+n,4)-1.
- Second word W1 = W0+4, wrapping modulo 2^DM_ADDRESS; lanes 0..o+n-5.
- States: IDLE, A1, A2, CAP, RESP. Cycle T is the accept edge.
  - Load, no split: A1 at T+1 (mem_re=1, mem_addr=W0). CAP at T+2 captures mem_rdata. RESP at T+3.
  - Load, split: A1 at T+1 issues W0. A2 at T+2 issues W1 and captures the W0 data. CAP at T+3 captures the W1 data. RESP at T+4.
  - Store, no split: A1 at T+1 (mem_wr=lane mask, mem_addr=W0, mem_wdata=wd<<8*o). RESP at T+2.
  - Store, split: A1 at T+1 writes W0 with lanes o..3. A2 at T+2 writes W1 with lanes 0..o+n-5 and mem_wdata=wd>>8*(4-o). RESP at T+3.
  - RESP: resp_valid=1 for exactly one cycle, then IDLE. req_ready is low in RESP, so the back-to-back accept interval is RESP+1.
- mem_re and mem_wr are 0 in IDLE, CAP and RESP. mem_wr is 0 for loads; mem_re is 0 for stores.
- Load assembly: take {W1data,W0data}>>8*o, keep the low n bytes, then sign- or zero-extend to 32 bits. rd is registered and updates only when entering RESP.
- Store responses leave rd unchanged.
- Reset mid-operation: the FSM aborts to IDLE at once and no further memory strobes are issued. A split store aborted after A1 leaves W0 partially written; this is accepted behaviour and no response is produced.

Test Plan:
- Aligned store and load: SW addr=0x010 wd=0xDEADBEEF gives mem_wr=1111 at T+1 and resp at T+2. Then LW 0x010 gives rd=0xDEADBEEF at T+3.
- Byte store and signed/unsigned loads: SB addr=0x013 wd=0x00000080 gives mem_wr=1000 and mem_wdata[31:24]=0x80. LB 0x013 gives rd=0xFFFFFF80; LBU gives rd=0x00000080.
- Halfword store and load: SH addr=0x022 wd=0x0000F00D gives mem_wr=1100. LH gives rd=0xFFFFF00D; Funct3=101 (LHU) gives rd=0x0000F00D.
- Split store: SW addr=0x006 wd=0x44332211.
  - T+1: mem_addr=0x004, mem_wr=1100, lanes 2,3=0x11,0x22.
  - T+2: mem_addr=0x008, mem_wr=0011, lanes 0,1=0x33,0x44.
  - Then LW 0x006 gives rd=0x44332211 at T+4.
- Wrap split: LH addr=0x1FF issues W0=0x1FC then W1=0x000. rd = sign-extended {mem[0x000].b0, mem[0x1FF]}.
- Reset during split store: assert reset in A2. mem_wr=0 on the following cycle, resp_valid is never asserted, and req_ready=1 once reset deasserts. Only W0's lanes are written.
